// File: rtl/regfile_pkg.sv
// regfile_pkg: shared state encoding, address-width helper and byte-lane merge for regfile_mp.
package regfile_pkg;
    typedef enum logic {IDLE, SWEEP} state_t;
    localparam int MAX_WIDTH = 1024;
    localparam int MAX_BYTES = MAX_WIDTH / 8;
    function automatic int addr_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction
    // Callers zero-extend into MAX_WIDTH and truncate the result back to their entry width.
    function automatic logic [MAX_WIDTH-1:0] merge_be(
        input logic [MAX_WIDTH-1:0] old_v,
        input logic [MAX_WIDTH-1:0] new_v,
        input logic [MAX_BYTES-1:0] be
    );
        logic [MAX_WIDTH-1:0] res;
        for (int i = 0; i < MAX_BYTES; i++)
            res[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        return res;
    endfunction
endpackage

// File: rtl/regfile_rd_port.sv
// regfile_rd_port: one registered read port with hold-on-idle; REGFILE_BYPASS_EN adds
// same-cycle write forwarding and sweep-zero forwarding.
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic [AW-1:0]          addr,
    input  logic [DEPTH*WIDTH-1:0] mem_flat,
`ifdef REGFILE_BYPASS_EN
    input  logic                   wr_fire,
    input  logic [AW-1:0]          wr_addr,
    input  logic [WIDTH/8-1:0]     wr_be,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   sweep,
    input  logic [AW-1:0]          ptr,
`endif
    output logic [WIDTH-1:0]       data
);
    logic [WIDTH-1:0] entry, next_val;
    assign entry = mem_flat[addr*WIDTH +: WIDTH];
`ifdef REGFILE_BYPASS_EN
    // The entry being swept this cycle is zero after the edge, so forward zero.
    always_comb
        next_val = (sweep && ptr == addr) ? '0 :
                   (wr_fire && wr_addr == addr) ?
                   WIDTH'(merge_be(MAX_WIDTH'(entry), MAX_WIDTH'(wr_data), MAX_BYTES'(wr_be))) :
                   entry;
`else
    assign next_val = entry;
`endif
    always_ff @(posedge clk) begin
        if (reset)
            data <= '0;
        else if (en)
            data <= next_val;
    end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: DEPTH x WIDTH register file, one byte-masked write port, NRD registered read
// ports and a one-entry-per-cycle clear sweep; REGFILE_BYPASS_EN enables read forwarding.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 8,
    parameter  int NRD   = 2,
    localparam int AW    = addr_width(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [AW-1:0]          wr_addr,
    input  logic [WIDTH/8-1:0]     wr_be,
    input  logic [WIDTH-1:0]       wr_data,
    output logic                   wr_ready,
    input  logic [NRD-1:0]         rd_en,
    input  logic [NRD*AW-1:0]      rd_addr,
    output logic [NRD*WIDTH-1:0]   rd_data,
    input  logic                   clr_req,
    output logic                   busy,
    output logic                   clr_done
);
    state_t state, state_nx;
    logic [AW-1:0] ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH*WIDTH-1:0] mem_flat;
    logic sweep, wr_fire;

    assign sweep    = state == SWEEP;
    assign busy     = sweep;
    assign wr_ready = !sweep;
    assign clr_done = sweep && ptr == AW'(DEPTH - 1);
    assign wr_fire  = wr_en && wr_ready;

    always_comb
        state_nx = sweep ? (clr_done ? IDLE : SWEEP) : (clr_req ? SWEEP : IDLE);

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // ptr rests at 0 in IDLE, so a new sweep always starts from entry 0.
    always_ff @(posedge clk) begin
        if (reset || !sweep)
            ptr <= '0;
        else
            ptr <= ptr + AW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (sweep)
            mem[ptr] <= '0;
        else if (wr_fire)
            mem[wr_addr] <= WIDTH'(merge_be(MAX_WIDTH'(mem[wr_addr]), MAX_WIDTH'(wr_data),
                                            MAX_BYTES'(wr_be)));
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_flat
        assign mem_flat[i*WIDTH +: WIDTH] = mem[i];
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        regfile_rd_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_rd (
            .clk      (clk),
            .reset    (reset),
            .en       (rd_en[p]),
            .addr     (rd_addr[p*AW +: AW]),
            .mem_flat (mem_flat),
`ifdef REGFILE_BYPASS_EN
            .wr_fire  (wr_fire),
            .wr_addr  (wr_addr),
            .wr_be    (wr_be),
            .wr_data  (wr_data),
            .sweep    (sweep),
            .ptr      (ptr),
`endif
            .data     (rd_data[p*WIDTH +: WIDTH])
        );
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: randomized and directed checks of regfile_mp against a cycle-level reference model.
module tb_regfile_mp;
    localparam int W = 32, D = 8, N = 2, AW = 3;

    logic clk = 0;
    logic reset, wr_en, clr_req;
    logic [AW-1:0] wr_addr;
    logic [W/8-1:0] wr_be;
    logic [W-1:0] wr_data;
    logic wr_ready, busy, clr_done;
    logic [N-1:0] rd_en;
    logic [N*AW-1:0] rd_addr;
    logic [N*W-1:0] rd_data;

    int vectors = 0, miscompares = 0;

    logic [W-1:0] m_mem [D];
    logic [W-1:0] m_rd [N];
    bit m_sweep;
    int m_cnt;

    always #5 clk = ~clk;

    regfile_mp #(.WIDTH(W), .DEPTH(D), .NRD(N)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
        .wr_data(wr_data), .wr_ready(wr_ready), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .clr_req(clr_req), .busy(busy), .clr_done(clr_done)
    );

    function automatic logic [W-1:0] merge(input logic [W-1:0] o, input logic [W-1:0] n,
                                           input logic [W/8-1:0] be);
        logic [W-1:0] r = o;
        for (int b = 0; b < W/8; b++)
            if (be[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    // Advance one clock: the model consumes the inputs seen at the edge, outputs settle 1ns later.
    task automatic tick();
        logic [W-1:0] pre [D];
        logic [W-1:0] v;
        int a;
        bit wacc;
        @(posedge clk);
        if (reset) begin
            foreach (m_mem[i]) m_mem[i] = '0;
            foreach (m_rd[i]) m_rd[i] = '0;
            m_sweep = 0;
            m_cnt = 0;
        end else begin
            pre = m_mem;
            wacc = wr_en && !m_sweep;
            for (int p = 0; p < N; p++)
                if (rd_en[p]) begin
                    a = int'(rd_addr[p*AW +: AW]);
                    v = pre[a];
`ifdef REGFILE_BYPASS_EN
                    if (wacc && a == int'(wr_addr)) v = merge(pre[a], wr_data, wr_be);
                    if (m_sweep && a == m_cnt) v = '0;
`endif
                    m_rd[p] = v;
                end
            if (wacc) m_mem[wr_addr] = merge(m_mem[wr_addr], wr_data, wr_be);
            if (m_sweep) begin
                m_mem[m_cnt] = '0;
                if (m_cnt == D - 1) m_sweep = 0;
                else m_cnt++;
            end else if (clr_req) begin
                m_sweep = 1;
                m_cnt = 0;
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        wr_en = 0; clr_req = 0; rd_en = '0; wr_be = '0; wr_data = '0; wr_addr = '0; rd_addr = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        tick(); tick();
        reset = 0;
        tick();
        vectors++;
        if ({wr_ready, busy, clr_done} !== 3'b100) begin
            miscompares++;
            $display("FAIL reset_flags got=%b want=100", {wr_ready, busy, clr_done});
        end
        for (int a = 0; a < D; a++) begin
            rd_en = 2'b11;
            rd_addr = {AW'(a), AW'(a)};
            tick();
            vectors++;
            if (rd_data !== '0) begin
                miscompares++;
                $display("FAIL reset_read addr=%0d got=%h want=0", a, rd_data);
            end
        end
        rd_en = '0;
    endtask

    task automatic test_byte_write();
        wr_en = 1; wr_addr = 3; wr_be = 4'b1111; wr_data = 32'hDEADBEEF;
        tick();
        wr_be = 4'b0001; wr_data = 32'h000000AA;
        tick();
        wr_en = 0; rd_en = 2'b01; rd_addr = {AW'(0), AW'(3)};
        tick();
        rd_en = '0;
        vectors++;
        if (rd_data[W-1:0] !== 32'hDEADBEAA) begin
            miscompares++;
            $display("FAIL byte_write got=%h want=deadbeaa", rd_data[W-1:0]);
        end
        vectors++;
        if (rd_data[2*W-1:W] !== m_rd[1]) begin
            miscompares++;
            $display("FAIL port1_hold got=%h want=%h", rd_data[2*W-1:W], m_rd[1]);
        end
    endtask

    task automatic test_bypass();
        logic [W-1:0] old_v, want;
        wr_en = 1; wr_addr = 5; wr_be = 4'b1111; wr_data = 32'h0BADF00D;
        tick();
        old_v = m_mem[5];
        wr_data = 32'h12345678; rd_en = 2'b01; rd_addr = {AW'(0), AW'(5)};
`ifdef REGFILE_BYPASS_EN
        want = 32'h12345678;
`else
        want = old_v;
`endif
        tick();
        wr_en = 0;
        vectors++;
        if (rd_data[W-1:0] !== want) begin
            miscompares++;
            $display("FAIL same_cycle_read got=%h want=%h", rd_data[W-1:0], want);
        end
        tick();
        rd_en = '0;
        vectors++;
        if (rd_data[W-1:0] !== 32'h12345678) begin
            miscompares++;
            $display("FAIL stored_after_write got=%h want=12345678", rd_data[W-1:0]);
        end
    endtask

    task automatic fill_all();
        wr_en = 1; wr_be = 4'b1111;
        for (int a = 0; a < D; a++) begin
            wr_addr = AW'(a);
            wr_data = $urandom | 32'h1;
            tick();
        end
        wr_en = 0;
    endtask

    task automatic read_all_check(input string tag, input int keep_addr, input logic [W-1:0] keep_val);
        logic [W-1:0] want;
        for (int a = 0; a < D; a++) begin
            rd_en = 2'b11;
            rd_addr = {AW'(D - 1 - a), AW'(a)};
            tick();
            want = (a == keep_addr) ? keep_val : '0;
            vectors++;
            if (rd_data[W-1:0] !== want || rd_data[2*W-1:W] !== m_rd[1]) begin
                miscompares++;
                $display("FAIL %s addr=%0d got=%h/%h want=%h/%h", tag, a, rd_data[W-1:0],
                         rd_data[2*W-1:W], want, m_rd[1]);
            end
        end
        rd_en = '0;
    endtask

    task automatic test_sweep();
        int busy_cycles = 0, done_count = 0, done_at = 0;
        fill_all();
        clr_req = 1;
        tick();
        clr_req = 0;
        wr_en = 1; wr_addr = 2; wr_be = 4'b1111; wr_data = 32'hCAFE0002;
        for (int c = 0; c < 20 && busy; c++) begin
            busy_cycles++;
            vectors++;
            if (wr_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL sweep_wr_ready cycle=%0d got=%b want=0", busy_cycles, wr_ready);
            end
            if (clr_done) begin
                done_count++;
                done_at = busy_cycles;
            end
            tick();
        end
        vectors++;
        if (busy_cycles != D || done_count != 1 || done_at != D) begin
            miscompares++;
            $display("FAIL sweep_timing busy=%0d done_count=%0d done_at=%0d want=%0d/1/%0d",
                     busy_cycles, done_count, done_at, D, D);
        end
        vectors++;
        if (wr_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL post_sweep_ready got=%b want=1", wr_ready);
        end
        tick();
        wr_en = 0;
        read_all_check("sweep_contents", 2, 32'hCAFE0002);
    endtask

    task automatic test_reset_mid_sweep();
        int dones = 0;
        fill_all();
        clr_req = 1;
        tick();
        clr_req = 0;
        tick(); tick();
        reset = 1;
        tick();
        reset = 0;
        vectors++;
        if ({busy, clr_done, wr_ready} !== 3'b001) begin
            miscompares++;
            $display("FAIL reset_abort_flags got=%b want=001", {busy, clr_done, wr_ready});
        end
        for (int c = 0; c < 10; c++) begin
            if (clr_done || busy) dones++;
            tick();
        end
        vectors++;
        if (dones != 0) begin
            miscompares++;
            $display("FAIL reset_abort_no_done got=%0d cycles busy/done want=0", dones);
        end
        read_all_check("reset_abort_contents", -1, '0);
    endtask

    task automatic test_write_with_clr();
        int c;
        wr_en = 1; wr_addr = 1; wr_be = 4'b1111; wr_data = 32'h00000055; clr_req = 1;
        tick();
        wr_en = 0; clr_req = 0;
        rd_en = 2'b01; rd_addr = {AW'(0), AW'(1)};
        tick();
        rd_en = '0;
        vectors++;
        if (rd_data[W-1:0] !== 32'h00000055) begin
            miscompares++;
            $display("FAIL write_before_sweep got=%h want=00000055", rd_data[W-1:0]);
        end
        for (c = 0; c < 20 && busy; c++) tick();
        vectors++;
        if (busy) begin
            miscompares++;
            $display("FAIL sweep_timeout busy still high after %0d cycles", c);
        end
        read_all_check("write_with_clr", -1, '0);
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            reset   = ($urandom_range(0, 99) == 0);
            wr_en   = $urandom_range(0, 1) == 1;
            wr_addr = AW'($urandom_range(0, D - 1));
            wr_be   = 4'($urandom);
            wr_data = $urandom;
            rd_en   = 2'($urandom);
            rd_addr = 6'($urandom);
            clr_req = ($urandom_range(0, 19) == 0);
            tick();
            vectors++;
            if (rd_data[W-1:0] !== m_rd[0] || rd_data[2*W-1:W] !== m_rd[1] ||
                busy !== m_sweep || wr_ready !== !m_sweep ||
                clr_done !== (m_sweep && m_cnt == D - 1)) begin
                miscompares++;
                $display("FAIL random cycle=%0d got rd=%h/%h b=%b r=%b d=%b want rd=%h/%h b=%b",
                         c, rd_data[W-1:0], rd_data[2*W-1:W], busy, wr_ready, clr_done,
                         m_rd[0], m_rd[1], m_sweep);
            end
        end
        reset = 0;
        idle_inputs();
        for (int c = 0; c < 20 && busy; c++) tick();
    endtask

    initial begin
        test_reset();
        test_byte_write();
        test_bypass();
        test_sweep();
        test_reset_mid_sweep();
        test_write_with_clr();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
